dii_wormhole_mux: RTL and testbench

- Generalised N-input wormhole multiplexer for DII flit streams (data/last/valid/ready), used at ring router gateways and debug-interconnect merge points.
- Selects one input, then forwards its whole worm, head to last flit, without interleaving.
- Adds three things over a fixed 3-input priority mux:
  - parametrised channel count and width;
  - selectable fixed-priority or round-robin arbitration;
  - a grant that stays stable while the output stalls, plus an optional output register stage.

---
 rtl/dii_wormhole_mux.sv | 227 ++++++++++++++++++++++
 tb/tb_dii_wormhole_mux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dii_wormhole_mux.sv
`default_nettype none
// ============================================================================
//  Module      : dii_wormhole_mux
//  Description : N-input wormhole multiplexer for DII flit streams
//                (data/last/valid/ready). Each worm is forwarded from head
//                to last flit without interleaving. Arbitration is either
//                fixed priority or round-robin. An optional register stage
//                can be placed on the output.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    in_data      in   CHANNELS*DATA_WIDTH flit data, channel i at
//                      [i*DATA_WIDTH +: DATA_WIDTH]
//    in_last      in   per-channel last-flit marker
//    in_valid     in   per-channel flit valid
//    in_ready     out  per-channel flit accepted (at most one bit set)
//    out_data     out  muxed flit data
//    out_last     out  muxed last marker
//    out_valid    out  muxed valid
//    out_ready    in   downstream ready
//    active       out  a channel is granted (worm running or head pending)
//    active_chan  out  granted channel index, 0 when !active
// ============================================================================
module dii_wormhole_mux #(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ARB_RR     = 0,
    parameter int OUTPUT_REG = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]            in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           active,
    output logic [$clog2(CHANNELS)-1:0]    active_chan
);

    localparam int                 c_IDX_W     = $clog2(CHANNELS);
    localparam logic [c_IDX_W-1:0] c_LAST_CHAN = c_IDX_W'(CHANNELS - 1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_GRANTED = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_grant;
    logic [c_IDX_W-1:0]    w_grant_nxt;
    logic [c_IDX_W-1:0]    w_arb_chan;
    logic [c_IDX_W-1:0]    w_sel_chan;
    logic                  w_any_valid;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_dn_ready;
    logic                  w_xfer;
    logic                  w_worm_end;
    logic [DATA_WIDTH-1:0] w_chan_data [CHANNELS];

    // ------------------------------------------------------------------
    // Unpack the flat data bus into per-channel words
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_chan_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_any_valid = |in_valid;

    // ------------------------------------------------------------------
    // Arbiter: only consulted while IDLE
    // ------------------------------------------------------------------
    generate
        if (ARB_RR != 0) begin : g_arb_rr
            logic [c_IDX_W-1:0] r_ptr;

            // Search p, p+1, ... wrapping; first valid channel wins.
            always_comb begin
                int                 idx;
                logic               found;
                logic [c_IDX_W-1:0] cand;
                idx        = 0;
                found      = 1'b0;
                cand       = '0;
                w_arb_chan = '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= CHANNELS) begin
                        idx = idx - CHANNELS;
                    end
                    cand = c_IDX_W'(idx);
                    if (!found && in_valid[cand]) begin
                        found      = 1'b1;
                        w_arb_chan = cand;
                    end
                end
            end

            // Pointer only advances when a worm completes; stalls and
            // bubbles leave it untouched.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_worm_end) begin
                    r_ptr <= (w_sel_chan == c_LAST_CHAN) ? '0 : w_sel_chan + 1'b1;
                end
            end
        end else begin : g_arb_fixed
            // Scan from the top so the lowest valid index is written last.
            always_comb begin
                w_arb_chan = '0;
                for (int k = CHANNELS - 1; k >= 0; k--) begin
                    if (in_valid[k]) begin
                        w_arb_chan = c_IDX_W'(k);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Channel selection: locked grant while a worm is in flight, live
    // arbitration result while IDLE (so the head goes out this cycle).
    // ------------------------------------------------------------------
    assign w_sel_chan  = (r_state == c_ST_GRANTED) ? r_grant : w_arb_chan;
    assign w_sel_valid = in_valid[w_sel_chan] & ~rst;
    assign w_sel_last  = in_last[w_sel_chan];
    assign w_sel_data  = w_chan_data[w_sel_chan];

    assign w_xfer     = w_sel_valid & w_dn_ready;
    assign w_worm_end = w_xfer & w_sel_last;

    assign active      = (r_state == c_ST_GRANTED) | w_any_valid;
    assign active_chan = active ? w_sel_chan : '0;

    // Only the granted channel ever sees ready; held low throughout reset.
    always_comb begin
        in_ready = '0;
        if (!rst && active) begin
            in_ready[w_sel_chan] = w_dn_ready;
        end
    end

    // ------------------------------------------------------------------
    // Grant state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            c_ST_IDLE: begin
                // A single-flit worm accepted here never leaves IDLE. Any
                // other outcome (multi-flit head or stalled head) locks the
                // grant so a stall can not be re-arbitrated away.
                if (w_any_valid && !w_worm_end) begin
                    w_state_nxt = c_ST_GRANTED;
                    w_grant_nxt = w_arb_chan;
                end
            end
            c_ST_GRANTED: begin
                if (w_worm_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  r_out_valid;
            logic                  r_out_last;
            logic [DATA_WIDTH-1:0] r_out_data;

            // Stage may load when empty or when it drains this cycle,
            // which sustains one flit per cycle.
            assign w_dn_ready = ~r_out_valid | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_data  <= '0;
                end else if (w_dn_ready) begin
                    r_out_valid <= w_xfer;
                    r_out_last  <= w_sel_last;
                    r_out_data  <= w_sel_data;
                end
            end

            assign out_valid = r_out_valid;
            assign out_last  = r_out_last;
            assign out_data  = r_out_data;
        end else begin : g_out_comb
            assign w_dn_ready = out_ready;
            assign out_valid  = w_sel_valid;
            assign out_last   = w_sel_last;
            assign out_data   = w_sel_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dii_wormhole_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dii_wormhole_mux
//  Description : Self-checking bench for dii_wormhole_mux. Three instances
//                share one stimulus bus: fixed priority (combinational),
//                round-robin (combinational) and fixed priority with the
//                output register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dii_wormhole_mux;

    localparam int c_CH = 3;
    localparam int c_DW = 16;
    localparam logic [47:0] c_TBL_DATA = {16'h00C2, 16'h00B1, 16'h00A0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 r_rst       = 1'b1;
    logic [c_CH*c_DW-1:0] r_in_data   = '0;
    logic [c_CH-1:0]      r_in_last   = '0;
    logic [c_CH-1:0]      r_in_valid  = '0;
    logic                 r_out_ready = 1'b1;

    logic [c_CH-1:0] w_fp_ir,  w_rr_ir,  w_rg_ir;
    logic [c_DW-1:0] w_fp_od,  w_rr_od,  w_rg_od;
    logic            w_fp_ol,  w_rr_ol,  w_rg_ol;
    logic            w_fp_ov,  w_rr_ov,  w_rg_ov;
    logic            w_fp_act, w_rr_act, w_rg_act;
    logic [1:0]      w_fp_ach, w_rr_ach, w_rg_ach;

    dii_wormhole_mux #(.CHANNELS(c_CH), .DATA_WIDTH(c_DW), .ARB_RR(0), .OUTPUT_REG(0)) u_fp (
        .clk(clk), .rst(r_rst), .in_data(r_in_data), .in_last(r_in_last),
        .in_valid(r_in_valid), .in_ready(w_fp_ir), .out_data(w_fp_od),
        .out_last(w_fp_ol), .out_valid(w_fp_ov), .out_ready(r_out_ready),
        .active(w_fp_act), .active_chan(w_fp_ach));

    dii_wormhole_mux #(.CHANNELS(c_CH), .DATA_WIDTH(c_DW), .ARB_RR(1), .OUTPUT_REG(0)) u_rr (
        .clk(clk), .rst(r_rst), .in_data(r_in_data), .in_last(r_in_last),
        .in_valid(r_in_valid), .in_ready(w_rr_ir), .out_data(w_rr_od),
        .out_last(w_rr_ol), .out_valid(w_rr_ov), .out_ready(r_out_ready),
        .active(w_rr_act), .active_chan(w_rr_ach));

    dii_wormhole_mux #(.CHANNELS(c_CH), .DATA_WIDTH(c_DW), .ARB_RR(0), .OUTPUT_REG(1)) u_rg (
        .clk(clk), .rst(r_rst), .in_data(r_in_data), .in_last(r_in_last),
        .in_valid(r_in_valid), .in_ready(w_rg_ir), .out_data(w_rg_od),
        .out_last(w_rg_ol), .out_valid(w_rg_ov), .out_ready(r_out_ready),
        .active(w_rg_act), .active_chan(w_rg_ach));

    typedef struct {
        string       name;
        logic        rst;
        int          dut;     // 0 fixed, 1 round-robin
        logic [2:0]  valid;
        logic [2:0]  last;
        logic        ordy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_ol;
        logic [2:0]  e_ir;
        logic        e_act;
        logic [1:0]  e_ach;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [47:0] pk(input logic [15:0] d0, input logic [15:0] d1,
                                       input logic [15:0] d2);
        return {d2, d1, d0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic rst, input int dut, input logic [2:0] v,
                       input logic [2:0] l, input logic ordy, input logic e_ov,
                       input logic [15:0] e_od, input logic e_ol, input logic [2:0] e_ir,
                       input logic e_act, input logic [1:0] e_ach);
        vec_t t;
        t.name = nm; t.rst = rst; t.dut = dut; t.valid = v; t.last = l; t.ordy = ordy;
        t.e_ov = e_ov; t.e_od = e_od; t.e_ol = e_ol; t.e_ir = e_ir;
        t.e_act = e_act; t.e_ach = e_ach;
        vecs.push_back(t);
    endtask

    // Compare one instance's outputs; data/last only meaningful with valid.
    task automatic check_out(input string nm, input int dut, input logic e_ov,
                             input logic [15:0] e_od, input logic e_ol, input logic [2:0] e_ir,
                             input logic e_act, input logic [1:0] e_ach);
        logic ov, ol, act;
        logic [15:0] od;
        logic [2:0] ir;
        logic [1:0] ach;
        case (dut)
            0: begin ov = w_fp_ov; od = w_fp_od; ol = w_fp_ol; ir = w_fp_ir; act = w_fp_act; ach = w_fp_ach; end
            1: begin ov = w_rr_ov; od = w_rr_od; ol = w_rr_ol; ir = w_rr_ir; act = w_rr_act; ach = w_rr_ach; end
            default: begin ov = w_rg_ov; od = w_rg_od; ol = w_rg_ol; ir = w_rg_ir; act = w_rg_act; ach = w_rg_ach; end
        endcase
        chk({nm, " out_valid"}, 32'(ov), 32'(e_ov));
        if (e_ov) begin
            chk({nm, " out_data"}, 32'(od), 32'(e_od));
            chk({nm, " out_last"}, 32'(ol), 32'(e_ol));
        end
        chk({nm, " in_ready"},    32'(ir),  32'(e_ir));
        chk({nm, " active"},      32'(act), 32'(e_act));
        chk({nm, " active_chan"}, 32'(ach), 32'(e_ach));
    endtask

    // Drive just after the rising edge, then wait to mid-cycle for sampling.
    task automatic step(input logic [2:0] v, input logic [2:0] l, input logic ordy,
                        input logic [47:0] d);
        @(posedge clk); #1;
        r_in_valid = v; r_in_last = l; r_out_ready = ordy; r_in_data = d;
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        r_rst = 1'b1; r_in_valid = '0; r_in_last = '0; r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pat [4];
        int          idx, nout, last_t;
        logic        ov_t0, ov_t1, ov_t9;
        logic [2:0]  ir_t1;

        // ---------------- vector table ----------------
        //   name           rst dut valid   last    rdy ov od      ol  ir      act ach
        add("rst_hold",     1, 0, 3'b000, 3'b000, 1, 0, 16'h0,  0, 3'b000, 0, 2'd0);
        add("post_rst",     0, 0, 3'b000, 3'b000, 1, 0, 16'h0,  0, 3'b000, 0, 2'd0);
        add("fp_all_a",     0, 0, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("fp_all_b",     0, 0, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("fp_all_c",     0, 0, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("fp_ch12",      0, 0, 3'b110, 3'b111, 1, 1, 16'hB1, 1, 3'b010, 1, 2'd1);
        add("fp_ch2",       0, 0, 3'b100, 3'b111, 1, 1, 16'hC2, 1, 3'b100, 1, 2'd2);
        add("fp_stall",     0, 0, 3'b100, 3'b111, 0, 1, 16'hC2, 1, 3'b000, 1, 2'd2);
        add("fp_locked",    0, 0, 3'b111, 3'b111, 1, 1, 16'hC2, 1, 3'b100, 1, 2'd2);
        add("fp_rearb",     0, 0, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("rr_rst",       1, 1, 3'b000, 3'b000, 1, 0, 16'h0,  0, 3'b000, 0, 2'd0);
        add("rr_0",         0, 1, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("rr_1",         0, 1, 3'b111, 3'b111, 1, 1, 16'hB1, 1, 3'b010, 1, 2'd1);
        add("rr_2",         0, 1, 3'b111, 3'b111, 1, 1, 16'hC2, 1, 3'b100, 1, 2'd2);
        add("rr_wrap",      0, 1, 3'b111, 3'b111, 1, 1, 16'hA0, 1, 3'b001, 1, 2'd0);
        add("rr_skip",      0, 1, 3'b101, 3'b111, 1, 1, 16'hC2, 1, 3'b100, 1, 2'd2);
        add("rr_after_wrap",0, 1, 3'b110, 3'b111, 1, 1, 16'hB1, 1, 3'b010, 1, 2'd1);

        do_reset();
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            r_rst = vecs[i].rst; r_in_valid = vecs[i].valid; r_in_last = vecs[i].last;
            r_out_ready = vecs[i].ordy; r_in_data = c_TBL_DATA;
            #4;
            check_out(vecs[i].name, vecs[i].dut, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ol,
                      vecs[i].e_ir, vecs[i].e_act, vecs[i].e_ach);
        end

        // ---------------- wormhole lock (fixed priority) ----------------
        do_reset();
        step(3'b010, 3'b000, 1, pk(16'h0A, 16'h10, 16'h0));
        check_out("lock_f0", 0, 1, 16'h10, 0, 3'b010, 1, 2'd1);
        step(3'b010, 3'b000, 1, pk(16'h0A, 16'h11, 16'h0));
        check_out("lock_f1", 0, 1, 16'h11, 0, 3'b010, 1, 2'd1);
        step(3'b011, 3'b001, 1, pk(16'h0A, 16'h12, 16'h0));
        check_out("lock_f2", 0, 1, 16'h12, 0, 3'b010, 1, 2'd1);
        step(3'b001, 3'b001, 1, pk(16'h0A, 16'h0, 16'h0));
        check_out("lock_bubble", 0, 0, 16'h0, 0, 3'b010, 1, 2'd1);
        step(3'b011, 3'b011, 1, pk(16'h0A, 16'h13, 16'h0));
        check_out("lock_f3", 0, 1, 16'h13, 1, 3'b010, 1, 2'd1);
        step(3'b001, 3'b001, 1, pk(16'h0A, 16'h0, 16'h0));
        check_out("lock_next", 0, 1, 16'h0A, 1, 3'b001, 1, 2'd0);
        step(3'b000, 3'b000, 1, pk(16'h0, 16'h0, 16'h0));
        check_out("lock_idle", 0, 0, 16'h0, 0, 3'b000, 0, 2'd0);

        // ---------------- stall stability ----------------
        do_reset();
        step(3'b100, 3'b000, 0, pk(16'h0, 16'h0, 16'h55));
        check_out("stall_c1", 0, 1, 16'h55, 0, 3'b000, 1, 2'd2);
        for (int c = 2; c <= 5; c++) begin
            step(3'b101, 3'b001, 0, pk(16'h0B, 16'h0, 16'h55));
            check_out($sformatf("stall_c%0d", c), 0, 1, 16'h55, 0, 3'b000, 1, 2'd2);
        end
        step(3'b101, 3'b001, 1, pk(16'h0B, 16'h0, 16'h55));
        check_out("stall_release", 0, 1, 16'h55, 0, 3'b100, 1, 2'd2);
        step(3'b101, 3'b101, 1, pk(16'h0B, 16'h0, 16'h56));
        check_out("stall_tail", 0, 1, 16'h56, 1, 3'b100, 1, 2'd2);
        step(3'b001, 3'b001, 1, pk(16'h0B, 16'h0, 16'h0));
        check_out("stall_next", 0, 1, 16'h0B, 1, 3'b001, 1, 2'd0);

        // ---------------- output register, ready 1,0,1,1 ----------------
        do_reset();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        idx = 0; nout = 0; last_t = -1;
        ov_t0 = 1'bx; ov_t1 = 1'bx; ov_t9 = 1'bx; ir_t1 = 'x;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            r_out_ready = pat[t % 4];
            r_in_valid  = (idx < 6) ? 3'b001 : 3'b000;
            r_in_last   = (idx == 5) ? 3'b001 : 3'b000;
            r_in_data   = pk(16'(16'h60 + idx), 16'h0, 16'h0);
            #4;
            if (t == 0) ov_t0 = w_rg_ov;
            if (t == 1) begin ov_t1 = w_rg_ov; ir_t1 = w_rg_ir; end
            if (t == 9) ov_t9 = w_rg_ov;
            if (w_rg_ov && r_out_ready) begin
                chk($sformatf("oreg_data%0d", nout), 32'(w_rg_od), 32'(16'h60 + nout));
                chk($sformatf("oreg_last%0d", nout), 32'(w_rg_ol), 32'(nout == 5));
                nout++;
                last_t = t;
            end
            if (r_in_valid[0] && w_rg_ir[0]) idx++;
        end
        chk("oreg_ov_t0", 32'(ov_t0), 32'(0));
        chk("oreg_ov_t1", 32'(ov_t1), 32'(1));
        chk("oreg_ir_t1", 32'(ir_t1), 32'(0));
        chk("oreg_count", 32'(nout), 32'(6));
        chk("oreg_last_cycle", 32'(last_t), 32'(8));
        chk("oreg_drained", 32'(ov_t9), 32'(0));

        // ---------------- reset mid-worm (round-robin) ----------------
        do_reset();
        step(3'b010, 3'b010, 1, pk(16'h0, 16'h70, 16'h0));
        check_out("mr_pre", 1, 1, 16'h70, 1, 3'b010, 1, 2'd1);
        step(3'b100, 3'b000, 1, pk(16'h0, 16'h0, 16'h80));
        check_out("mr_f0", 1, 1, 16'h80, 0, 3'b100, 1, 2'd2);
        step(3'b100, 3'b000, 1, pk(16'h0, 16'h0, 16'h81));
        check_out("mr_f1", 1, 1, 16'h81, 0, 3'b100, 1, 2'd2);
        @(posedge clk); #1;
        r_rst = 1'b1; r_in_valid = 3'b100; r_in_data = pk(16'h0, 16'h0, 16'h82);
        #4;
        chk("mr_rst_in_ready", 32'(w_rr_ir), 32'(0));
        chk("mr_rst_out_valid", 32'(w_rr_ov), 32'(0));
        @(posedge clk); #1;
        r_rst = 1'b0; r_in_valid = 3'b000; r_in_last = 3'b000;
        #4;
        check_out("mr_after_rst", 1, 0, 16'h0, 0, 3'b000, 0, 2'd0);
        step(3'b110, 3'b110, 1, pk(16'h0, 16'h71, 16'h72));
        check_out("mr_new_p0", 1, 1, 16'h71, 1, 3'b010, 1, 2'd1);
        step(3'b100, 3'b100, 1, pk(16'h0, 16'h0, 16'h72));
        check_out("mr_new_next", 1, 1, 16'h72, 1, 3'b100, 1, 2'd2);

        @(posedge clk); #1;
        r_in_valid = '0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
